// File: rtl/mips_mc_control_if.sv
// mips_mc_control_if: IR/ALU/memory status in, datapath enables and selects out
// master (control FSM): in  opcode[5:0] funct[5:0] zero mem_ready
//                       out pc_write ir_write mem_write reg_write iord mem_to_reg
//                           reg_dst alu_src_a alu_src_b[1:0] pc_src[1:0]
//                           alu_control[2:0] illegal_op state_o[3:0]
// slave (datapath): the same signals with directions reversed
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       iord;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_control;
  logic       illegal_op;
  logic [3:0] state_o;
  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, state_o
  );
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, state_o
  );
endinterface

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS control FSM with memory-ready stalls
// clk: rising-edge clock; reset: asynchronous active-low, forces FETCH and all outputs 0
// bus (mips_mc_control_if.master): opcode/funct/zero/mem_ready in, enables/selects/alu_control/
//   illegal_op/state_o out
// MIPS_MC_BNE_EN: when defined, opcode 000101 (bne) branches on ~zero; otherwise it is illegal
module mips_mc_control #(
  parameter int OPW = 6
) (
  input logic clk,
  input logic reset,
  mips_mc_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;
  localparam logic [OPW-1:0] OP_R    = OPW'('b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'('b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'('b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'('b000100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'('b001000);
  localparam logic [OPW-1:0] OP_J    = OPW'('b000010);
  state_t state, nxt;
  logic pcw, irw, mw, rw, io, m2r, rd, sa, ill, valid, br_ne;
  logic [1:0] sb, ps, aluop;
  logic [2:0] alu_ctl;
`ifdef MIPS_MC_BNE_EN
  localparam logic [OPW-1:0] OP_BNE = OPW'('b000101);
  logic bne_q;
  // remembers which branch flavour was decoded, since BRANCH no longer samples the opcode
  always_ff @(posedge clk or negedge reset)
    if (!reset) bne_q <= 1'b0;
    else if (state == DECODE) bne_q <= bus.opcode == OP_BNE;
  assign br_ne = bne_q;
`else
  assign br_ne = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else state <= nxt;
  always_comb begin
    nxt = FETCH;
    pcw = 1'b0;
    irw = 1'b0;
    mw = 1'b0;
    rw = 1'b0;
    io = 1'b0;
    m2r = 1'b0;
    rd = 1'b0;
    sa = 1'b0;
    ill = 1'b0;
    valid = 1'b1;
    sb = 2'b00;
    ps = 2'b00;
    aluop = 2'b00;
    case (state)
      FETCH: begin
        sb = 2'b01;
        pcw = bus.mem_ready;
        irw = bus.mem_ready;
        nxt = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        sb = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R: nxt = EXECUTE;
          OP_BEQ: nxt = BRANCH;
          OP_ADDI: nxt = ADDIEXEC;
          OP_J: nxt = JUMP;
`ifdef MIPS_MC_BNE_EN
          OP_BNE: nxt = BRANCH;
`endif
          default: ill = 1'b1;
        endcase
      end
      MEMADR: begin
        sa = 1'b1;
        sb = 2'b10;
        nxt = bus.opcode == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        io = 1'b1;
        nxt = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        m2r = 1'b1;
        rw = 1'b1;
      end
      MEMWR: begin
        io = 1'b1;
        mw = 1'b1;
        nxt = bus.mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        sa = 1'b1;
        aluop = 2'b10;
        nxt = ALUWB;
      end
      ALUWB: begin
        rd = 1'b1;
        rw = 1'b1;
      end
      BRANCH: begin
        sa = 1'b1;
        aluop = 2'b01;
        ps = 2'b01;
        pcw = bus.zero ^ br_ne;
      end
      ADDIEXEC: begin
        sa = 1'b1;
        sb = 2'b10;
        nxt = ADDIWB;
      end
      ADDIWB: rw = 1'b1;
      JUMP: begin
        ps = 2'b10;
        pcw = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end
  assign alu_ctl = aluop == 2'b01 ? 3'b110 :
                   aluop != 2'b10 ? 3'b010 :
                   bus.funct == 6'b100010 ? 3'b110 :
                   bus.funct == 6'b100100 ? 3'b000 :
                   bus.funct == 6'b100101 ? 3'b001 :
                   bus.funct == 6'b101010 ? 3'b111 : 3'b010;
  // outputs are gated by reset so nothing stays asserted while reset is held low
  assign bus.pc_write = reset & pcw;
  assign bus.ir_write = reset & irw;
  assign bus.mem_write = reset & mw;
  assign bus.reg_write = reset & rw;
  assign bus.iord = reset & io;
  assign bus.mem_to_reg = reset & m2r;
  assign bus.reg_dst = reset & rd;
  assign bus.alu_src_a = reset & sa;
  assign bus.alu_src_b = reset ? sb : 2'b00;
  assign bus.pc_src = reset ? ps : 2'b00;
  assign bus.alu_control = (reset && valid) ? alu_ctl : 3'b000;
  assign bus.illegal_op = reset & ill;
  assign bus.state_o = reset ? 4'(state) : 4'b0000;
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: directed instruction traces checked cycle by cycle against a trace model
module tb_mips_mc_control;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010, BNE = 6'b000101, BAD = 6'b111111;
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [19:0] exp;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  ent_t q[$];
  int checks = 0;
  int errors = 0;
  logic [5:0] cfn;
  logic cz;
  always #5 clk = ~clk;
  mips_mc_control_if bus();
  mips_mc_control dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [19:0] outs();
    return {bus.state_o, bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.iord,
            bus.mem_to_reg, bus.reg_dst, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
            bus.alu_control, bus.illegal_op};
  endfunction
  function automatic logic [2:0] alu_r(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction
  function automatic logic legal(input logic [5:0] op);
`ifdef MIPS_MC_BNE_EN
    if (op == BNE) return 1'b1;
`endif
    return op == R || op == LW || op == SW || op == BEQ || op == ADDI || op == J;
  endfunction
  function automatic int lat(input logic [5:0] op);
    if (!legal(op)) return 2;
    if (op == LW) return 5;
    if (op == BEQ || op == BNE || op == J) return 3;
    return 4;
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, got, exp);
    end
  endtask
  // one expected cycle: enables are {pc_write,ir_write,mem_write,reg_write,iord,mem_to_reg,reg_dst,alu_src_a}
  task automatic add(input logic [3:0] st, input logic [7:0] en, input logic [1:0] sb,
                     input logic [1:0] ps, input logic [2:0] ac, input logic ill,
                     input logic mr, input logic [5:0] op);
    ent_t e;
    e.op = op;
    e.fn = cfn;
    e.z = cz;
    e.mr = mr;
    e.exp = {st, en, sb, ps, ac, ill};
    q.push_back(e);
  endtask
  // opcode is only meaningful in DECODE and MEMADR, so other cycles carry a junk opcode
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fst, input int mst);
    int n0;
    cfn = fn;
    cz = z;
    n0 = q.size();
    repeat (fst) add(0, 8'h00, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0, BAD);
    add(0, 8'hc0, 2'b01, 2'b00, 3'b010, 1'b0, 1'b1, BAD);
    add(1, 8'h00, 2'b11, 2'b00, 3'b010, !legal(op), 1'b0, op);
    if (legal(op)) begin
      if (op == LW || op == SW) begin
        add(2, 8'h01, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0, op);
        repeat (mst) add(op == LW ? 4'd3 : 4'd5, op == LW ? 8'h08 : 8'h28, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, BAD);
        add(op == LW ? 4'd3 : 4'd5, op == LW ? 8'h08 : 8'h28, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1, BAD);
        if (op == LW) add(4, 8'h14, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, BAD);
      end else if (op == R) begin
        add(6, 8'h01, 2'b00, 2'b00, alu_r(fn), 1'b0, 1'b0, BAD);
        add(7, 8'h12, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, BAD);
      end else if (op == BEQ || op == BNE) begin
        add(8, {(op == BEQ) ? z : ~z, 7'b0000001}, 2'b00, 2'b01, 3'b110, 1'b0, 1'b0, BAD);
      end else if (op == ADDI) begin
        add(9, 8'h01, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0, BAD);
        add(10, 8'h10, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, BAD);
      end else begin
        add(11, 8'h80, 2'b00, 2'b10, 3'b010, 1'b0, 1'b0, BAD);
      end
    end
    chk("latency", q.size() - n0 - fst - mst, lat(op));
  endtask
  task automatic run();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      bus.opcode = e.op;
      bus.funct = e.fn;
      bus.zero = e.z;
      bus.mem_ready = e.mr;
      @(negedge clk);
      chk($sformatf("cycle_op%b_st%0d", e.op, e.exp[19:16]), outs(), e.exp);
    end
  endtask
  initial begin
    bus.opcode = LW;
    bus.funct = 6'b100000;
    bus.zero = 1'b1;
    bus.mem_ready = 1'b1;
    #3;
    chk("reset_outputs", outs(), 20'h0);
    @(negedge clk);
    chk("reset_held", outs(), 20'h0);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("fetch_idle", outs(), {4'd0, 8'h00, 2'b01, 2'b00, 3'b010, 1'b0});
    chk("pin_slt", alu_r(6'b101010), 3'b111);
    chk("pin_bad_funct", alu_r(6'b111111), 3'b010);
    instr(LW, 6'b100000, 1'b0, 0, 0);
    instr(R, 6'b101010, 1'b0, 3, 0);
    instr(BEQ, 6'b000000, 1'b1, 0, 0);
    instr(BEQ, 6'b000000, 1'b0, 0, 0);
    instr(SW, 6'b000000, 1'b0, 1, 2);
    instr(LW, 6'b000000, 1'b1, 0, 1);
    instr(ADDI, 6'b100010, 1'b0, 0, 0);
    instr(J, 6'b000000, 1'b0, 0, 0);
    instr(R, 6'b100010, 1'b1, 0, 0);
    instr(R, 6'b100100, 1'b0, 0, 0);
    instr(R, 6'b100101, 1'b0, 0, 0);
    instr(R, 6'b100000, 1'b0, 0, 0);
    instr(R, 6'b111111, 1'b0, 0, 0);
    instr(BAD, 6'b000000, 1'b0, 0, 0);
    instr(BNE, 6'b000000, 1'b0, 0, 0);
    instr(BNE, 6'b000000, 1'b1, 0, 0);
    run();
    cfn = 6'b000000;
    cz = 1'b0;
    add(0, 8'hc0, 2'b01, 2'b00, 3'b010, 1'b0, 1'b1, BAD);
    add(1, 8'h00, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0, SW);
    add(2, 8'h01, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0, SW);
    add(5, 8'h28, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, BAD);
    add(5, 8'h28, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, BAD);
    run();
    #2;
    reset = 1'b0;
    #1;
    chk("reset_mid_memwr_state", 32'(bus.state_o), 32'd0);
    chk("reset_mid_memwr_strobe", 32'(bus.mem_write), 32'd0);
    chk("reset_mid_memwr_all", outs(), 20'h0);
    @(negedge clk);
    reset = 1'b1;
    instr(J, 6'b000000, 1'b0, 0, 0);
    instr(ADDI, 6'b000000, 1'b0, 2, 0);
    run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Main control unit of the multicycle MIPS core: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback.
- Drives the write enable of the PC register directly (pc_write).
- Also drives IR/regfile/memory enables, datapath mux selects and ALU control.
- Adds a memory-ready handshake so fetch and data accesses can stall.

Parameters:
- OPW, 6, opcode/funct field width (fixed 6; parameter exists for lint only)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- opcode  input  6  instr[31:26] from IR
- funct  input  6  instr[5:0] from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes access this cycle
- pc_write  output  1  PC register write enable
- ir_write  output  1  instruction register load
- mem_write  output  1  data memory write strobe
- reg_write  output  1  register file write
- iord  output  1  mem address select: 0=PC, 1=ALUOut
- mem_to_reg  output  1  writeback select: 0=ALUOut, 1=MDR
- reg_dst  output  1  dest reg: 0=rt, 1=rd
- alu_src_a  output  1  0=PC, 1=A
- alu_src_b  output  2  00=B, 01=4, 10=signimm, 11=signimm<<2
- pc_src  output  2  00=ALUResult, 01=ALUOut, 10=jump target
- alu_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  output  1  one-cycle pulse, unknown opcode in DECODE
- state_o  output  4  current state encoding (debug)

Behaviour:
- Reset (reset=0, async):
  - state = FETCH (0).
  - While reset is low, every output is forced to 0, including alu_control = 000 and state_o = 0.
- Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12-15 return to FETCH next cycle with all outputs 0.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Defaults in every state: all enables 0, all selects 0, aluop 00. Each state asserts only the items listed below.
- FETCH:
  - alu_src_b=01; ir_write = pc_write = mem_ready.
  - Next: DECODE if mem_ready, else stay.
- DECODE:
  - alu_src_b=11 (branch target into ALUOut).
  - Next: lw/sw -> MEMADR; R -> EXECUTE; beq -> BRANCH; addi -> ADDIEXEC; j -> JUMP.
  - Any other opcode -> FETCH with illegal_op=1.
- MEMADR: alu_src_a=1, alu_src_b=10. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. Next: MEMWB when mem_ready, else stay.
- MEMWB: mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWR:
  - iord=1; mem_write=1, held high for every cycle in the state.
  - Next: FETCH when mem_ready, else stay.
- EXECUTE: alu_src_a=1, aluop=10 -> ALUWB.
- ALUWB: reg_dst=1, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=1, aluop=01, pc_src=01; pc_write = zero -> FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10 -> ADDIWB.
- ADDIWB: reg_write=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- ALU decode (combinational):
  - aluop 00 -> 010; aluop 01 -> 110.
  - aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 010.
- Timing: opcode/funct are sampled only in DECODE and MEMADR. Latency per instruction excluding stalls: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
- Reset low mid-instruction: immediate return to FETCH; no partial write enable may remain asserted.

Optional Feature:
- Macro: MIPS_MC_BNE_EN.
- Defined:
  - Opcode 000101 (bne) goes DECODE -> BRANCH.
  - In BRANCH, pc_write = ~zero for bne and zero for beq. The FSM registers a bne flag in DECODE for this purpose.
- Undefined: 000101 is treated as illegal (illegal_op pulse, return to FETCH).

Test Plan:
- reset=0 mid-MEMWR with mem_ready=0 -> state_o=0, mem_write=0 immediately, before the next clk edge.
- lw (opcode 100011), mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in MEMWB; pc_write=1 only in FETCH.
- FETCH with mem_ready=0 for 3 cycles then 1 -> state stays 0; pc_write/ir_write stay 0 until the ready cycle, then both are 1 for exactly one cycle.
- beq with zero=1 -> pc_write=1, pc_src=01 in BRANCH. With zero=0 -> pc_write=0. Path length 3 cycles in both cases.
- R-type funct 101010 -> alu_control=111 in EXECUTE; ALUWB has reg_dst=1, reg_write=1.
- opcode 111111 -> illegal_op=1 for one cycle in DECODE, next state 0. Opcode 000101 gives the same result with MIPS_MC_BNE_EN undefined; with it defined, zero=0 -> pc_write=1.
